// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared definitions for the register-file debug dump sequencer:
// FSM state encoding, default geometry and byte-count helpers.
package regfile_dump_ctrl_pkg;

  localparam int DEF_WIDTH_B   = 32;
  localparam int DEF_ADDR_B    = 5;
  localparam int BYTES_PER_REG = DEF_WIDTH_B / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_HDR,
    ST_SEND,
    ST_NEXT,
    ST_FIN
  } state_e;

  // Number of bytes in a word of width_b bits (width_b is a multiple of 8).
  function automatic int bytes_per_reg(input int width_b);
    return width_b / 8;
  endfunction

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Byte stream (valid/ready) from the dump sequencer toward the UART transmitter.
interface regfile_dump_ctrl_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/regfile_dump_ctrl_byte_serializer.sv
// Loads a DATA_W-bit word and emits it MSB-first as bytes on a valid/ready
// stream. Output byte and valid come straight from registers, so they hold
// steady while the consumer stalls.
module regfile_dump_ctrl_byte_serializer
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_WIDTH_B
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_hs,
  output logic              o_last
);

  localparam int NBYTES = bytes_per_reg(DATA_W);
  localparam int CW     = cnt_width(NBYTES);

  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_valid;
  logic              w_hs;

  assign w_hs    = r_valid && i_ready;
  assign o_hs    = w_hs;
  assign o_last  = w_hs && (r_cnt == '0);
  assign o_data  = r_shift[DATA_W-1 -: 8];
  assign o_valid = r_valid;

  // Load a word, then shift one byte out per accepted handshake.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is reset even though it is datapath, because
    // its top byte is the visible tx_data and must read zero out of reset.
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= CW'(NBYTES - 1);
      r_valid <= 1'b1;
    end else if (w_hs) begin
      r_shift <= r_shift << 8;
      r_cnt   <= r_cnt - CW'(1);
      if (r_cnt == '0) r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Debug sequencer sharing register-file read port 1 with the pipeline.
// On dbg_start it freezes the pipeline, walks every register address and
// streams each register MSB-first as bytes toward the UART transmitter.
// The read-port address mux (selected by dbg_sel) lives at the level above.
// Optional: define REGDUMP_INDEX_EN to prefix each register with a header
// byte holding its zero-extended address (requires ADDR_B <= 8).
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int WIDTH_B = DEF_WIDTH_B,  // multiple of 8
  parameter int ADDR_B  = DEF_ADDR_B
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dbg_start,
  input  logic                  pipe_stalled,
  output logic                  stall_req,
  output logic                  dbg_sel,
  output logic [ADDR_B-1:0]     dbg_rd_addr,
  input  logic [WIDTH_B-1:0]    rf_rd_data,
  regfile_dump_ctrl_if.master   tx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_B-1:0] ADDR_MAX = {ADDR_B{1'b1}};

`ifdef REGDUMP_INDEX_EN
  localparam int SER_W = WIDTH_B + 8;
`else
  localparam int SER_W = WIDTH_B;
`endif

  state_e            r_state;
  logic              r_stall_req;
  logic              r_dbg_sel;
  logic [ADDR_B-1:0] r_addr;
  logic              r_busy;
  logic              r_done;

  logic [SER_W-1:0]  w_ser_data;
  logic              w_load;
  logic              w_hs;
  logic              w_last;

`ifdef REGDUMP_INDEX_EN
  // Header byte first: the register address, zero-extended to 8 bits.
  assign w_ser_data = {8'(r_addr), rf_rd_data};
`else
  assign w_ser_data = rf_rd_data;
`endif

  assign w_load = (r_state == ST_LOAD);

  regfile_dump_ctrl_byte_serializer #(
    .DATA_W (SER_W)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (w_ser_data),
    .o_data  (tx.tx_data),
    .o_valid (tx.tx_valid),
    .i_ready (tx.tx_ready),
    .o_hs    (w_hs),
    .o_last  (w_last)
  );

  // Dump sequencer: stall handshake, address walk and registered status outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every branch sees
    // the values from before this edge, whatever the statement order.
    if (reset) begin
      r_state     <= ST_IDLE;
      r_stall_req <= 1'b0;
      r_dbg_sel   <= 1'b0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (dbg_start) begin
            r_state     <= ST_REQ;
            r_busy      <= 1'b1;
            r_stall_req <= 1'b1;
          end
        end
        // Wait indefinitely for the pipeline to confirm it is frozen.
        ST_REQ: begin
          if (pipe_stalled) begin
            r_dbg_sel <= 1'b1;
            r_addr    <= '0;
            r_state   <= ST_LOAD;
          end
        end
        // rf_rd_data for r_addr is captured by the serializer this cycle.
        ST_LOAD: begin
`ifdef REGDUMP_INDEX_EN
          r_state <= ST_HDR;
`else
          r_state <= ST_SEND;
`endif
        end
        // Header byte goes out; data bytes always follow it.
        ST_HDR: begin
          if (w_hs) r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_last) r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_addr == ADDR_MAX) begin
            r_state     <= ST_FIN;
            r_done      <= 1'b1;
            r_stall_req <= 1'b0;
            r_dbg_sel   <= 1'b0;
            r_busy      <= 1'b0;
            r_addr      <= '0;
          end else begin
            r_addr  <= r_addr + ADDR_B'(1);
            r_state <= ST_LOAD;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_req   = r_stall_req;
  assign dbg_sel     = r_dbg_sel;
  assign dbg_rd_addr = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl at default geometry (32-bit, 32 regs).
// Build with REGDUMP_INDEX_EN defined to exercise the header-byte variant.
module tb_regfile_dump_ctrl;

`ifdef REGDUMP_INDEX_EN
  localparam int PER_REG = 5;
`else
  localparam int PER_REG = 4;
`endif
  localparam int TOTAL   = 32 * PER_REG;
  localparam int TIMEOUT = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbg_start;
  logic        pipe_stalled;
  logic        stall_req;
  logic        dbg_sel;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] rf_rd_data;
  logic        busy;
  logic        done;

  regfile_dump_ctrl_if tx_if ();

  regfile_dump_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .dbg_start    (dbg_start),
    .pipe_stalled (pipe_stalled),
    .stall_req    (stall_req),
    .dbg_sel      (dbg_sel),
    .dbg_rd_addr  (dbg_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .tx           (tx_if),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Register file model with the top-level read-port mux; the pipeline side
  // points at a fixed address so a missing dbg_sel shows up as wrong data.
  logic [31:0] regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = 32'hA0B0C000 + 32'(i);
  assign rf_rd_data = regs[dbg_sel ? dbg_rd_addr : 5'd7];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: 0 = never ready, 1 = always ready, 2 = ~30% random.
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       tx_if.tx_ready = 1'b1;
      2:       tx_if.tx_ready = ($urandom_range(0, 9) < 3);
      default: tx_if.tx_ready = 1'b0;
    endcase
  end

  // Stream monitor: collects accepted bytes, counts done pulses and flags any
  // change of tx_data/tx_valid while the transmitter is stalling.
  logic [7:0] got [$];
  int         n_done     = 0;
  int         stable_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(tx_if.tx_valid && tx_if.tx_data == prev_data)) stable_err++;
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      if (tx_if.tx_valid && tx_if.tx_ready) got.push_back(tx_if.tx_data);
      if (done) n_done++;
    end
  end

  function automatic logic [7:0] exp_byte(input int k);
    int          r;
    int          b;
    logic [31:0] w;
    r = k / PER_REG;
    b = k % PER_REG;
    w = 32'hA0B0C000 + 32'(r);
`ifdef REGDUMP_INDEX_EN
    if (b == 0) return 8'(r);
    return w[8*(4-b) +: 8];
`else
    return w[8*(3-b) +: 8];
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_stall_req"}, stall_req,      0);
    check({tag, "_dbg_sel"},   dbg_sel,        0);
    check({tag, "_rd_addr"},   dbg_rd_addr,    0);
    check({tag, "_tx_data"},   tx_if.tx_data,  0);
    check({tag, "_tx_valid"},  tx_if.tx_valid, 0);
    check({tag, "_busy"},      busy,           0);
    check({tag, "_done"},      done,           0);
  endtask

  task automatic pulse_start();
    dbg_start = 1'b1;
    @(posedge clk); #1;
    dbg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    int cyc = 0;
    while (n_done == start && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_no_timeout"}, (cyc < TIMEOUT), 1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, n_done - start, 1);
  endtask

  task automatic verify_bytes(input string tag);
    int bad = 0;
    check({tag, "_byte_count"}, got.size(), TOTAL);
    for (int k = 0; k < got.size() && k < TOTAL; k++)
      if (got[k] !== exp_byte(k)) bad++;
    check({tag, "_bad_bytes"}, bad, 0);
    if (got.size() >= TOTAL) begin
      check({tag, "_first_byte"}, got[0], exp_byte(0));
      check({tag, "_last_byte"},  got[TOTAL-1], 8'h1F);
`ifdef REGDUMP_INDEX_EN
      check({tag, "_last_hdr"},   got[TOTAL-5], 8'h1F);
`endif
    end
  endtask

  initial begin
    int start;
    int viol;
    int cyc;

    reset        = 1'b1;
    dbg_start    = 1'b0;
    pipe_stalled = 1'b0;
    tx_if.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst_held");
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_idle");

    // Dump 1: grant 3 cycles after the request, ready always high,
    // plus a second dbg_start mid-dump that must be ignored.
    got.delete();
    start = n_done;
    ready_mode = 1;
    pulse_start();
    check("d1_stall_lat", stall_req, 1);
    check("d1_busy",      busy,      1);
    check("d1_sel_pre",   dbg_sel,   0);
    repeat (2) @(posedge clk);
    #1;
    pipe_stalled = 1'b1;
    @(posedge clk); #1;
    check("d1_sel_grant",  dbg_sel,        1);
    check("d1_valid_load", tx_if.tx_valid, 0);
    @(posedge clk); #1;
    check("d1_valid_first", tx_if.tx_valid, 1);
    check("d1_data_first",  tx_if.tx_data,  exp_byte(0));
    repeat (20) @(posedge clk);
    #1;
    pulse_start();
    wait_done("d1", start);
    verify_bytes("d1");
    check_idle("d1_end");
    pipe_stalled = 1'b0;

    // Dump 2: random back-pressure must not alter the byte stream.
    got.delete();
    start = n_done;
    ready_mode = 2;
    pipe_stalled = 1'b1;
    pulse_start();
    wait_done("d2", start);
    verify_bytes("d2");
    check("d2_stable", stable_err, 0);
    pipe_stalled = 1'b0;

    // Dump 3: request held off by the pipeline for 50 cycles.
    got.delete();
    start = n_done;
    ready_mode = 1;
    pulse_start();
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      if (stall_req !== 1'b1 || dbg_sel !== 1'b0 || tx_if.tx_valid !== 1'b0) viol++;
      @(posedge clk); #1;
    end
    check("d3_hold_viol", viol, 0);
    pipe_stalled = 1'b1;
    wait_done("d3", start);
    verify_bytes("d3");
    pipe_stalled = 1'b0;

    // Dump 4: reset after the 37th byte, then a clean restart from reg 0.
    got.delete();
    start = n_done;
    pipe_stalled = 1'b1;
    pulse_start();
    cyc = 0;
    while (got.size() < 37 && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("d4_reach37", got.size(), 37);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle("d4_abort");
    reset = 1'b0;
    check("d4_no_done", n_done - start, 0);
    got.delete();
    start = n_done;
    @(posedge clk); #1;
    pulse_start();
    wait_done("d4r", start);
    verify_bytes("d4r");
    check_idle("d4r_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
